multi_flux_fifo: RTL and testbench
==================================

# multi_flux_fifo

Tagged multi-flux FIFO that forms the channel between two parallel-flux actors, such as the delay actor. It is the FIFO side of both `write_interface` and `read_interface`. It accepts `{tag,data}` words from a producer actor and stores them in FLUX independent first-word-fall-through queues. A consumer actor pops any single flux per cycle and sees that flux's head word in the same cycle.

## Interface
Parameters:
- FLUX, 2, number of parallel fluxes; FLUX ≥ 2.
- DATA_WIDTH, 8, payload width.
- DEPTH, 4, words per flux; power of two, ≥ 2.
- TAG_WIDTH, $clog2(FLUX), derived; not overridden.
- WIDTH, DATA_WIDTH+TAG_WIDTH, derived; width of the interface word.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- write_port.write  in  1  producer write strobe.
- write_port.din  in  WIDTH  `{tag, data}`; the tag occupies the MSBs.
- write_port.full  out  FLUX  per-flux full flag.
- read_port.read  in  FLUX  per-flux pop request; one-hot or zero.
- read_port.empty  out  FLUX  per-flux empty flag.
- read_port.dout  out  WIDTH  `{tag, head data}` of the flux currently being popped.

## Operation
- Each flux i is an independent circular buffer with:
  - DEPTH entries;
  - a write pointer, a read pointer, and a count, each $clog2(DEPTH)+1 bits wide (the pointers use their low $clog2(DEPTH) bits as the address).
- Flags are decoded from the registered counts:
  - empty[i] = (count_i == 0).
  - full[i] = (count_i == DEPTH).
- Push:
  - Occurs when write=1 and full[din tag]=0; data is stored at that flux's write pointer, which then increments and wraps.
  - A write to a full flux is dropped with no state change.
  - A tag ≥ FLUX is dropped.
- Pop:
  - sel is the lowest index with read[sel]=1.
  - If empty[sel]=0, the read pointer of sel advances and wraps.
  - Any other read bits set in the same cycle are ignored.
  - A pop of an empty flux is ignored.
- dout, combinational from read and the stored state:
  - While a pop is active: dout = {sel, head data of flux sel}.
  - When read==0 or flux sel is empty: dout = 0.
- Push and pop on the same flux in the same cycle:
  - Both take effect when the flags allow; the count is unchanged.
  - There is no write-through. A full flux rejects the write even while it is being popped.
  - An empty flux cannot return the word being written in that cycle.
- Push on flux a and pop on flux b (a≠b) in the same cycle are fully independent.
- Storage contents are not reset. Only pointers and counts are reset.

## Timing
- Reset values, effective the cycle after rst is sampled high:
  - empty = all ones.
  - full = all zeros.
  - dout = 0 while read = 0.
- rst mid-operation discards all queued words. Writes and reads in the rst cycle are ignored.
- Write-to-visible latency is 1 cycle: a push at edge N clears empty[tag] after edge N, and that word is poppable in cycle N+1.
- Read-to-data latency is 0: dout is valid in the same cycle read is asserted. The consumer samples it before edge N.
- full and empty change only on clock edges and carry no combinational path from read or write. This makes them safe for actor-side combinational tag selection.
- Throughput: one push and one pop per cycle, on any flux combination.

## Structure
- Shared package `flux_pkg`:
  - function `tag_width(flux)`;
  - typedef of the `{tag,data}` word built from parameters;
  - so that producer actors, consumer actors and this FIFO agree on packing.
- Sub-module `flux_fifo_lane`, instantiated FLUX times. Each lane is one FWFT circular buffer with:
  - push and pop inputs;
  - a head-data output;
  - empty and full outputs.
- The top level contains only:
  - tag decode (din tag → lane push);
  - priority selection of read;
  - the dout mux and tag concatenation.

## Test plan
- Reset: hold rst for 2 cycles with write=1 and read=2'b11 → empty=2'b11, full=2'b00, and no word is stored (later reads show empty).
- Single word: write din={1,8'hA5} at cycle 0 → empty=2'b01 in cycle 1. Then read=2'b10 → dout={1,8'hA5} in the same cycle, and empty=2'b11 the next cycle.
- Full/drop, FLUX=2, DEPTH=4:
  - Push 8'h10..8'h13 on flux 0 → full=2'b01.
  - Push 8'hFF on flux 0 → dropped.
  - Four pops return 10,11,12,13 in order, then empty[0]=1.
  - Flux 1 is untouched throughout.
- Simultaneous push/pop with wrap:
  - Preload 2 words on flux 1.
  - Run 6 cycles of push plus pop on flux 1 → count stays 2, full and empty stay 0, and the output order equals the input order across the pointer wrap.
- Full plus same-cycle pop: with flux 0 full, assert write(tag 0, 8'h77) and read=2'b01 → 8'h77 is rejected, count becomes 3, full[0]=0 next cycle.
- Multi-bit read and mid-run reset:
  - Both fluxes are non-empty; apply read=2'b11 → only flux 0 pops, and dout carries tag 0.
  - Then assert rst for 1 cycle → empty=2'b11, and no pre-reset word ever appears on dout.

Source files
------------

// File: rtl/flux_pkg.sv
// -----------------------------------------------------------------------------
// flux_pkg
// Definitions shared by producer actors, consumer actors and multi_flux_fifo.
// Keeping the {tag,data} packing in one place means every party agrees on the
// word layout.
//   tag_width(flux) : bits needed to name one of `flux` fluxes (never below 1)
//   flux_word_t     : {tag,data} word for the default FLUX/DATA_WIDTH
// -----------------------------------------------------------------------------
package flux_pkg;

   function automatic int tag_width(input int flux);
      return (flux > 1) ? $clog2(flux) : 1;
   endfunction

   localparam int FLUX_DEFAULT       = 2;
   localparam int DATA_WIDTH_DEFAULT = 8;
   localparam int TAG_WIDTH_DEFAULT  = tag_width(FLUX_DEFAULT);

   // The tag sits in the MSBs of the interface word.
   typedef struct packed {
      logic [TAG_WIDTH_DEFAULT-1:0]  tag;
      logic [DATA_WIDTH_DEFAULT-1:0] data;
   } flux_word_t;

endpackage

// File: rtl/flux_fifo_lane.sv
// -----------------------------------------------------------------------------
// flux_fifo_lane
// One first-word-fall-through circular buffer. The head word is always visible
// on head_o. Flags are decoded from the registered count, so they carry no
// combinational path from push_i or pop_i.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointers/count only)
//   push_i     push request; dropped while full
//   din_i      data to store
//   pop_i      pop request; ignored while empty
//   head_o     word at the read pointer
//   empty_o    count == 0
//   full_o     count == DEPTH
// -----------------------------------------------------------------------------
module flux_fifo_lane #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] head_o,
   output logic                  empty_o,
   output logic                  full_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         count_q,  count_d;
   logic                  push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == PW'(DEPTH));

   // A full lane rejects a push even if it is popped in the same cycle:
   // there is no write-through and no bypass.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   assign head_o = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + PW'(1);
         2'b01:   count_d = count_q - PW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately not reset; only the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/multi_flux_fifo.sv
// -----------------------------------------------------------------------------
// multi_flux_fifo
// Tagged FIFO between two parallel-flux actors. Words {tag,data} from the
// producer are steered by tag into FLUX independent FWFT lanes; the consumer
// pops one flux per cycle and sees that flux's head word in the same cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   write_i    producer write strobe
//   din_i      {tag,data}, tag in the MSBs
//   full_o     per-flux full flag (registered)
//   read_i     per-flux pop request; the lowest set bit wins
//   empty_o    per-flux empty flag (registered)
//   dout_o     {sel,head data} of the flux being popped, 0 when none/empty
// -----------------------------------------------------------------------------
module multi_flux_fifo
   import flux_pkg::*;
#(
   parameter  int FLUX       = 2,
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 4,
   localparam int TAG_WIDTH  = tag_width(FLUX),
   localparam int WIDTH      = DATA_WIDTH + TAG_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             write_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [FLUX-1:0]  full_o,
   input  logic [FLUX-1:0]  read_i,
   output logic [FLUX-1:0]  empty_o,
   output logic [WIDTH-1:0] dout_o
);

   logic [TAG_WIDTH-1:0]  din_tag;
   logic [DATA_WIDTH-1:0] din_data;
   logic                  tag_ok;
   logic [FLUX-1:0]       push;
   logic [FLUX-1:0]       pop;
   logic [TAG_WIDTH-1:0]  sel;
   logic                  sel_vld;
   logic [DATA_WIDTH-1:0] head [FLUX];

   assign din_tag  = din_i[WIDTH-1 -: TAG_WIDTH];
   assign din_data = din_i[DATA_WIDTH-1:0];
   // Tags naming a non-existent flux are dropped.
   assign tag_ok   = (int'(din_tag) < FLUX);

   // Priority select: walking downward leaves the lowest set bit in sel.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      for (int i = FLUX - 1; i >= 0; i--) begin
         if (read_i[i]) begin
            sel     = TAG_WIDTH'(i);
            sel_vld = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < FLUX; g++) begin : g_lane
      assign push[g] = write_i & tag_ok & (din_tag == TAG_WIDTH'(g));
      assign pop[g]  = sel_vld & (sel == TAG_WIDTH'(g));

      flux_fifo_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .push_i  (push[g]),
         .din_i   (din_data),
         .pop_i   (pop[g]),
         .head_o  (head[g]),
         .empty_o (empty_o[g]),
         .full_o  (full_o[g])
      );
   end

   assign dout_o = (sel_vld && !empty_o[sel]) ? {sel, head[sel]} : '0;

endmodule

// File: tb/tb_multi_flux_fifo.sv
// -----------------------------------------------------------------------------
// tb_multi_flux_fifo
// Directed bench for multi_flux_fifo with FLUX=2, DATA_WIDTH=8, DEPTH=4.
// Inputs change 1 ns after the rising edge; outputs are compared a further
// 2 ns later, well clear of either clock edge.
// -----------------------------------------------------------------------------
module tb_multi_flux_fifo;

   localparam int FLUX  = 2;
   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int W     = DW + 1;

   logic            clk;
   logic            rst;
   logic            write;
   logic [W-1:0]    din;
   logic [FLUX-1:0] full;
   logic [FLUX-1:0] read;
   logic [FLUX-1:0] empty;
   logic [W-1:0]    dout;

   int vec_cnt = 0;
   int miscmp  = 0;

   logic [W-1:0] exp_q [$];
   logic [W-1:0] exp_w;

   multi_flux_fifo #(
      .FLUX       (FLUX),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .write_i (write),
      .din_i   (din),
      .full_o  (full),
      .read_i  (read),
      .empty_o (empty),
      .dout_o  (dout)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic push_word(input logic tag, input logic [DW-1:0] data);
      write = 1'b1;
      din   = {tag, data};
      tick();
      write = 1'b0;
      din   = '0;
   endtask

   // checker
   task automatic check_vec(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miscmp++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst   = 1'b1;
      write = 1'b1;
      din   = {1'b1, 8'hA5};
      read  = 2'b11;

      // Reset held 2 cycles with write and read active: nothing is stored.
      tick();
      tick();
      rst   = 1'b0;
      write = 1'b0;
      din   = '0;
      read  = 2'b00;
      settle();
      check_vec("rst_empty", 32'(empty), 32'h3);
      check_vec("rst_full",  32'(full),  32'h0);
      check_vec("rst_dout",  32'(dout),  32'h0);
      read = 2'b10;
      settle();
      check_vec("rst_rd1_dout", 32'(dout), 32'h0);
      read = 2'b01;
      settle();
      check_vec("rst_rd0_dout", 32'(dout), 32'h0);
      tick();
      read = 2'b00;
      settle();
      check_vec("rst_rd_empty", 32'(empty), 32'h3);

      // Single word on flux 1, read back with zero latency.
      push_word(1'b1, 8'hA5);
      settle();
      check_vec("single_empty", 32'(empty), 32'h1);
      read = 2'b10;
      settle();
      check_vec("single_dout", 32'(dout), 32'h1A5);
      tick();
      read = 2'b00;
      settle();
      check_vec("single_empty_after", 32'(empty), 32'h3);

      // Fill flux 0, then a dropped write, then drain in order.
      for (int k = 0; k < DEPTH; k++) push_word(1'b0, 8'(8'h10 + k));
      settle();
      check_vec("fill_full",  32'(full),  32'h1);
      check_vec("fill_empty", 32'(empty), 32'h2);
      push_word(1'b0, 8'hFF);
      settle();
      check_vec("drop_full", 32'(full), 32'h1);
      read = 2'b01;
      for (int k = 0; k < DEPTH; k++) begin
         settle();
         check_vec($sformatf("drain_dout%0d", k), 32'(dout), 32'(9'h010 + k));
         tick();
      end
      read = 2'b00;
      settle();
      check_vec("drain_empty", 32'(empty), 32'h3);
      check_vec("drain_full",  32'(full),  32'h0);

      // Simultaneous push/pop on flux 1 across the pointer wrap.
      exp_q.delete();
      for (int k = 0; k < 2; k++) begin
         push_word(1'b1, 8'(8'h20 + k));
         exp_q.push_back({1'b1, 8'(8'h20 + k)});
      end
      for (int k = 0; k < 6; k++) begin
         write = 1'b1;
         din   = {1'b1, 8'(8'h22 + k)};
         read  = 2'b10;
         exp_q.push_back({1'b1, 8'(8'h22 + k)});
         settle();
         exp_w = exp_q.pop_front();
         check_vec($sformatf("pp_dout%0d", k), 32'(dout), 32'(exp_w));
         tick();
         settle();
         check_vec($sformatf("pp_flags%0d", k), 32'({full, empty}), 32'h1);
      end
      write = 1'b0;
      din   = '0;
      while (exp_q.size() > 0) begin
         settle();
         exp_w = exp_q.pop_front();
         check_vec("pp_tail_dout", 32'(dout), 32'(exp_w));
         tick();
      end
      read = 2'b00;
      settle();
      check_vec("pp_final_empty", 32'(empty), 32'h3);

      // Full flux 0 with a same-cycle pop: the write is still rejected.
      for (int k = 0; k < DEPTH; k++) push_word(1'b0, 8'(8'h30 + k));
      write = 1'b1;
      din   = {1'b0, 8'h77};
      read  = 2'b01;
      settle();
      check_vec("fullpop_dout", 32'(dout), 32'h030);
      tick();
      write = 1'b0;
      din   = '0;
      read  = 2'b00;
      settle();
      check_vec("fullpop_full", 32'(full), 32'h0);
      read = 2'b01;
      for (int k = 1; k < DEPTH; k++) begin
         settle();
         check_vec($sformatf("fullpop_dout%0d", k), 32'(dout), 32'(9'h030 + k));
         tick();
      end
      read = 2'b00;
      settle();
      check_vec("fullpop_empty", 32'(empty), 32'h3);

      // Multi-bit read: only flux 0 pops. Then a mid-run reset.
      push_word(1'b0, 8'h40);
      push_word(1'b0, 8'h41);
      push_word(1'b1, 8'h50);
      read = 2'b11;
      settle();
      check_vec("multi_dout", 32'(dout), 32'h040);
      tick();
      read = 2'b00;
      settle();
      check_vec("multi_empty", 32'(empty), 32'h0);
      read = 2'b10;
      settle();
      check_vec("multi_f1_dout", 32'(dout), 32'h150);
      read = 2'b00;
      rst  = 1'b1;
      tick();
      rst = 1'b0;
      settle();
      check_vec("midrst_empty", 32'(empty), 32'h3);
      read = 2'b01;
      settle();
      check_vec("midrst_rd0", 32'(dout), 32'h0);
      read = 2'b10;
      settle();
      check_vec("midrst_rd1", 32'(dout), 32'h0);
      tick();
      read = 2'b00;
      push_word(1'b1, 8'h60);
      read = 2'b10;
      settle();
      check_vec("post_rst_dout", 32'(dout), 32'h160);
      tick();
      read = 2'b00;
      settle();
      check_vec("post_rst_empty", 32'(empty), 32'h3);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
      $finish;
   end

endmodule
